// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving active-low one-hot select lines. A grant is held
// until the owner strobes done or the optional hold limit forces a release.
module rr_select_arbiter #(
    parameter int SIZE     = 2,
    parameter int HOLD_MAX = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [(1<<SIZE)-1:0]  req,
    input  logic                  done,
    output logic [(1<<SIZE)-1:0]  sel_n,
    output logic [SIZE-1:0]       gnt_idx,
    output logic                  busy,
    output logic                  timeout
);

    localparam int N = 1 << SIZE;
    localparam logic [N-1:0]  ONE_HOT0  = N'(1);
    localparam logic [15:0]   HOLD_LAST = 16'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state;
    logic [SIZE-1:0] ptr;
    logic [15:0]     cnt;

    logic            pick_valid;
    logic [SIZE-1:0] pick_idx;
    logic [SIZE-1:0] cand;
    logic            hold_expired;

    // Walk offsets from N down to 1 so the smallest offset (ptr+1) wins last;
    // offset N wraps to ptr itself, which therefore has the lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr;
        cand       = ptr;
        for (int i = N; i >= 1; i--) begin
            cand = ptr + SIZE'(i);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign hold_expired = (HOLD_MAX != 0) && (cnt == HOLD_LAST);

    // NOTE: every register here is updated with <= so all of them see the
    // values from before the edge; blocking writes would leak between them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel_n   <= '1;
            gnt_idx <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            cnt     <= '0;
            ptr     <= '1;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (pick_valid) begin
                        state   <= BUSY;
                        sel_n   <= ~(ONE_HOT0 << pick_idx);
                        gnt_idx <= pick_idx;
                        busy    <= 1'b1;
                        ptr     <= pick_idx;
                    end
                end
                BUSY: begin
                    if (done || hold_expired) begin
                        // done outranks the hold limit, so timeout only
                        // fires on a release the owner did not ask for.
                        state   <= IDLE;
                        sel_n   <= '1;
                        busy    <= 1'b0;
                        cnt     <= '0;
                        timeout <= !done;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    sel_n <= '1;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/rr_select_arbiter.md
RR_SELECT_ARBITER -- requirements
Module: rr_select_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 2, meaning select-index width; requester count N = 2**SIZE.
REQ-002 SHALL have parameter HOLD_MAX, default 16, meaning maximum grant length in cycles (16-bit); 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block has one clock only.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  input  N  per-requester request, active-high, level.
REQ-006 SHALL have port done  input  1  release strobe from the current owner, active-high.
REQ-007 SHALL have port sel_n  output  N  registered select lines, active-low one-hot (all ones when idle).
REQ-008 SHALL have port gnt_idx  output  SIZE  registered index of the current owner.
REQ-009 SHALL have port busy  output  1  registered; 1 while a grant is held.
REQ-010 SHALL have port timeout  output  1  registered one-cycle pulse marking a forced release.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (no owner) and BUSY (one owner).
REQ-012 In IDLE with req != 0 at edge k, SHALL enter BUSY at edge k with sel_n = ~(1 << g), gnt_idx = g, busy = 1. Latency is 1 cycle from sampled req to visible select.
REQ-013 In IDLE with req == 0, SHALL stay in IDLE with sel_n all ones and busy = 0.
REQ-014 SHALL choose g round-robin from pointer ptr (last granted index). Search order is ptr+1, ptr+2, ... modulo N, with ptr itself searched last.
REQ-015 SHALL load ptr with g on every grant; ptr changes only on grant.
REQ-016 In BUSY, SHALL ignore req, including deassertion by the owner or by others. Only done or timeout releases the grant.
REQ-017 In BUSY with done = 1 at edge k, SHALL enter IDLE at edge k with sel_n all ones, busy = 0, timeout = 0.
REQ-018 In IDLE, SHALL ignore done.
REQ-019 SHALL hold a hold counter cnt at 0 in IDLE, clear it to 0 on grant, and increment it by 1 per BUSY cycle.
REQ-020 With HOLD_MAX != 0, in BUSY with done = 0 and cnt == HOLD_MAX-1 at edge k, SHALL release as in REQ-017 and drive timeout = 1 for exactly the cycle after edge k. Selection is therefore held at most HOLD_MAX cycles.
REQ-021 When done = 1 and the timeout condition are true in the same cycle, done SHALL take priority and timeout SHALL stay 0.
REQ-022 SHALL leave at least one IDLE cycle, with sel_n all ones, between successive grants. Back-to-back ownership is never permitted.
REQ-023 SHALL keep sel_n with at most one zero bit in every cycle, with gnt_idx equal to the index of that bit whenever busy = 1.
REQ-024 When busy = 0, SHALL hold gnt_idx at its last value (0 after reset).
REQ-025 SHALL be fully synthesizable with all outputs driven from registers, with no combinational path from inputs to outputs.

Reset
REQ-026 rst = 1 at an edge SHALL force IDLE, sel_n all ones, gnt_idx = 0, busy = 0, timeout = 0, cnt = 0, and ptr = N-1, so that the first search starts at index 0.
REQ-027 Reset asserted mid-grant SHALL drop the select at that edge. No done and no timeout pulse SHALL be produced.
REQ-028 While rst = 1, req SHALL be ignored. The first grant can appear one edge after rst deasserts.

Verification (SIZE=2, HOLD_MAX=4)
REQ-029 SHALL cover: after reset, req=4'b0010 -> next cycle sel_n=4'b1101, gnt_idx=1, busy=1; done pulse -> next cycle sel_n=4'b1111, busy=0.
REQ-030 SHALL cover: req=4'b1111 held, done pulsed every grant -> grant order 0,1,2,3,0, with one idle cycle (sel_n=4'b1111) between each grant.
REQ-031 SHALL cover: grant to 2, done never asserted -> sel_n=4'b1011 for exactly 4 cycles, then sel_n=4'b1111 with timeout=1 for 1 cycle.
REQ-032 SHALL cover: grant to 1, done=1 in the 4th BUSY cycle -> release with timeout=0.
REQ-033 SHALL cover: grant to 3, owner drops req while others request -> sel_n stays 4'b0111 until done; the next grant goes to 0 if req[0]=1.
REQ-034 SHALL cover: rst=1 during BUSY -> next cycle all outputs at reset values; then req=4'b1000 -> grant to 3, because search starts from 0 and only req[3] is set.
